// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the ID-stage hazard logic. The register-zero constant and the
// source-match helper are shared with the forwarding logic, so both blocks agree on
// what counts as a real dependency.
package hazard_unit_pkg;

  // $zero never carries a dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Width of the multiply/divide busy counter. This limits MD_LATENCY to 1..63.
  localparam int unsigned MD_CNT_W = 6;

  // Default width of the stall/flush performance counters.
  localparam int unsigned PERF_CNT_W = 32;

  // True when register r is a live source of the ID instruction.
  function automatic logic src_match(input logic [4:0] r,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       rt_used);
    return (r != REG_ZERO) && ((r == rs) || (rt_used && (r == rt)));
  endfunction

endpackage

// File: rtl/hazard_unit_md_busy_counter.sv
// Multiply/divide busy tracker.
//   clk_i   : pipeline clock, rising edge
//   rst_i   : asynchronous reset, active high
//   start_i : mult/div issued in EX this cycle; (re)loads LATENCY
//   busy_o  : counter nonzero; high for exactly LATENCY cycles after the last start
module hazard_unit_md_busy_counter
  import hazard_unit_pkg::*;
#(
  parameter int unsigned LATENCY = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic busy_o
);

  localparam logic [MD_CNT_W-1:0] LoadVal = MD_CNT_W'(LATENCY);

  logic [MD_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = LoadVal;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - MD_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Derived only from the register, so busy never sees start in the same cycle.
  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage MIPS pipeline, beside the ID stage.
// It covers the RAW cases forwarding cannot resolve: load-use, branch operands that are
// compared in ID, and the mult/div busy interlock. It also flushes IF/ID on a taken
// branch or jump.
//   IF_id_*            : fields and decode flags of the instruction in ID
//   ID_ex_*, EX_mem_*  : producer information from EX and MEM
//   md_start           : mult/div issued in EX this cycle
//   branch_taken, jump : control transfer resolved in ID
//   pc_write, IF_id_write, ID_ex_bubble, IF_id_flush : pipeline controls (combinational)
//   md_busy            : mult/div unit still computing
//   stall_count, flush_count : saturating performance counters
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 32,
  parameter int unsigned CNT_W      = PERF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IF_id_rs,
  input  logic [4:0]       IF_id_rt,
  input  logic             IF_id_uses_rt,
  input  logic             IF_id_is_branch,
  input  logic             IF_id_is_mfhilo,
  input  logic             IF_id_is_md,
  input  logic             ID_ex_memread,
  input  logic             ID_ex_regwrite,
  input  logic [4:0]       ID_ex_rd,
  input  logic             EX_mem_memread,
  input  logic [4:0]       EX_mem_rd,
  input  logic             md_start,
  input  logic             branch_taken,
  input  logic             jump,
  output logic             pc_write,
  output logic             IF_id_write,
  output logic             ID_ex_bubble,
  output logic             IF_id_flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  logic load_use, br_ex, br_mem, md_hz, stall;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  hazard_unit_md_busy_counter #(
    .LATENCY (MD_LATENCY)
  ) u_md_busy_counter (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (md_start),
    .busy_o  (md_busy)
  );

  // Branches compare both operands in ID, so rt is a source even when uses_rt is low.
  assign load_use = ID_ex_memread && src_match(ID_ex_rd, IF_id_rs, IF_id_rt, IF_id_uses_rt);
  assign br_ex    = IF_id_is_branch && ID_ex_regwrite &&
                    src_match(ID_ex_rd, IF_id_rs, IF_id_rt, 1'b1);
  assign br_mem   = IF_id_is_branch && EX_mem_memread &&
                    src_match(EX_mem_rd, IF_id_rs, IF_id_rt, 1'b1);
  assign md_hz    = md_busy && (IF_id_is_mfhilo || IF_id_is_md);
  assign stall    = load_use | br_ex | br_mem | md_hz;

  // A stall takes priority over a flush. A branch or jump held in ID is seen again
  // once the stall clears.
  always_comb begin
    pc_write     = 1'b1;
    IF_id_write  = 1'b1;
    ID_ex_bubble = 1'b0;
    IF_id_flush  = 1'b0;
    if (rst || stall) begin
      pc_write     = 1'b0;
      IF_id_write  = 1'b0;
      ID_ex_bubble = 1'b1;
    end else begin
      IF_id_flush = branch_taken | jump;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (IF_id_flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  localparam int unsigned MdLat  = 4;
  localparam int unsigned CntW   = 4;
  localparam int          CntMax = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [4:0]      IF_id_rs, IF_id_rt, ID_ex_rd, EX_mem_rd;
  logic            IF_id_uses_rt, IF_id_is_branch, IF_id_is_mfhilo, IF_id_is_md;
  logic            ID_ex_memread, ID_ex_regwrite, EX_mem_memread;
  logic            md_start, branch_taken, jump;
  logic            pc_write, IF_id_write, ID_ex_bubble, IF_id_flush, md_busy;
  logic [CntW-1:0] stall_count, flush_count;

  hazard_unit #(
    .MD_LATENCY (MdLat),
    .CNT_W      (CntW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .IF_id_rs        (IF_id_rs),
    .IF_id_rt        (IF_id_rt),
    .IF_id_uses_rt   (IF_id_uses_rt),
    .IF_id_is_branch (IF_id_is_branch),
    .IF_id_is_mfhilo (IF_id_is_mfhilo),
    .IF_id_is_md     (IF_id_is_md),
    .ID_ex_memread   (ID_ex_memread),
    .ID_ex_regwrite  (ID_ex_regwrite),
    .ID_ex_rd        (ID_ex_rd),
    .EX_mem_memread  (EX_mem_memread),
    .EX_mem_rd       (EX_mem_rd),
    .md_start        (md_start),
    .branch_taken    (branch_taken),
    .jump            (jump),
    .pc_write        (pc_write),
    .IF_id_write     (IF_id_write),
    .ID_ex_bubble    (ID_ex_bubble),
    .IF_id_flush     (IF_id_flush),
    .md_busy         (md_busy),
    .stall_count     (stall_count),
    .flush_count     (flush_count)
  );

  typedef struct {
    logic       rst;
    logic [4:0] rs, rt, ex_rd, mem_rd;
    logic       uses_rt, is_branch, is_mfhilo, is_md;
    logic       ex_memread, ex_regwrite, mem_memread;
    logic       md_start, taken, jump;
  } stim_t;

  typedef struct {
    string tag;
    logic  pc_write, if_write, bubble, flush, busy;
    int    sc, fc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state: cycles of mult/div work left and the two event totals.
  int md_left = 0;
  int stalls  = 0;
  int flushes = 0;

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0; s.rs = 5'd0; s.rt = 5'd0; s.ex_rd = 5'd0; s.mem_rd = 5'd0;
    s.uses_rt = 1'b0; s.is_branch = 1'b0; s.is_mfhilo = 1'b0; s.is_md = 1'b0;
    s.ex_memread = 1'b0; s.ex_regwrite = 1'b0; s.mem_memread = 1'b0;
    s.md_start = 1'b0; s.taken = 1'b0; s.jump = 1'b0;
    return s;
  endfunction

  function automatic bit reads(input logic [4:0] r, input stim_t s, input bit rt_src);
    return (r != 5'd0) && ((r == s.rs) || (rt_src && (r == s.rt)));
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CntMax) ? CntMax : v + 1;
  endfunction

  // Apply one cycle of stimulus, queue what the DUT must show before the next edge,
  // then advance the model across that edge.
  task automatic step(input string tag, input stim_t s);
    exp_t e;
    bit   hz;
    @(posedge clk);
    #1;
    rst = s.rst; IF_id_rs = s.rs; IF_id_rt = s.rt; IF_id_uses_rt = s.uses_rt;
    IF_id_is_branch = s.is_branch; IF_id_is_mfhilo = s.is_mfhilo; IF_id_is_md = s.is_md;
    ID_ex_memread = s.ex_memread; ID_ex_regwrite = s.ex_regwrite; ID_ex_rd = s.ex_rd;
    EX_mem_memread = s.mem_memread; EX_mem_rd = s.mem_rd;
    md_start = s.md_start; branch_taken = s.taken; jump = s.jump;
    if (s.rst) begin
      md_left = 0; stalls = 0; flushes = 0;
    end
    hz = (s.ex_memread && reads(s.ex_rd, s, s.uses_rt)) ||
         (s.is_branch && s.ex_regwrite && reads(s.ex_rd, s, 1'b1)) ||
         (s.is_branch && s.mem_memread && reads(s.mem_rd, s, 1'b1)) ||
         ((md_left > 0) && (s.is_mfhilo || s.is_md));
    e.tag = tag;
    e.busy = (md_left > 0);
    e.sc = stalls;
    e.fc = flushes;
    if (s.rst || hz) begin
      e.pc_write = 1'b0; e.if_write = 1'b0; e.bubble = 1'b1; e.flush = 1'b0;
    end else begin
      e.pc_write = 1'b1; e.if_write = 1'b1; e.bubble = 1'b0; e.flush = s.taken | s.jump;
    end
    exp_q.push_back(e);
    if (!s.rst) begin
      if (hz) stalls = sat_inc(stalls);
      if (e.flush) flushes = sat_inc(flushes);
      if (s.md_start) md_left = MdLat;
      else if (md_left > 0) md_left = md_left - 1;
    end
  endtask

  task automatic check(input string tag, input string what, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s %s: got %0d, expected %0d (t=%0t)", tag, what, act, req, $time);
    end
  endtask

  // Monitor: the DUT presents its outputs every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.tag, "pc_write", int'(pc_write), int'(e.pc_write));
      check(e.tag, "IF_id_write", int'(IF_id_write), int'(e.if_write));
      check(e.tag, "ID_ex_bubble", int'(ID_ex_bubble), int'(e.bubble));
      check(e.tag, "IF_id_flush", int'(IF_id_flush), int'(e.flush));
      check(e.tag, "md_busy", int'(md_busy), int'(e.busy));
      check(e.tag, "stall_count", int'(stall_count), e.sc);
      check(e.tag, "flush_count", int'(flush_count), e.fc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    rst = 1'b1;
    IF_id_rs = '0; IF_id_rt = '0; ID_ex_rd = '0; EX_mem_rd = '0;
    IF_id_uses_rt = 0; IF_id_is_branch = 0; IF_id_is_mfhilo = 0; IF_id_is_md = 0;
    ID_ex_memread = 0; ID_ex_regwrite = 0; EX_mem_memread = 0;
    md_start = 0; branch_taken = 0; jump = 0;

    // Reset state.
    s = idle(); s.rst = 1'b1;
    step("reset", s);
    step("reset", s);
    step("post_reset", idle());

    // Load-use hazard, then the same producer writing $zero.
    s = idle(); s.ex_memread = 1'b1; s.ex_regwrite = 1'b1; s.ex_rd = 5'd8; s.rs = 5'd8;
    step("load_use", s);
    s.ex_rd = 5'd0;
    step("load_use_r0", s);

    // lw $9 followed by beq $9,$10, which is taken.
    s = idle(); s.is_branch = 1'b1; s.rs = 5'd9; s.rt = 5'd10;
    s.ex_memread = 1'b1; s.ex_regwrite = 1'b1; s.ex_rd = 5'd9;
    step("br_ex", s);
    s.ex_memread = 1'b0; s.ex_regwrite = 1'b0; s.ex_rd = 5'd0;
    s.mem_memread = 1'b1; s.mem_rd = 5'd9;
    step("br_mem", s);
    s.mem_memread = 1'b0; s.mem_rd = 5'd0; s.taken = 1'b1;
    step("br_taken", s);
    step("br_after", idle());

    // MD interlock: mfhi waits out the full latency.
    s = idle(); s.md_start = 1'b1;
    step("md_start", s);
    s = idle(); s.is_mfhilo = 1'b1;
    for (int i = 0; i < 5; i++) step("md_wait", s);
    step("md_idle", idle());

    // A stall takes priority over a jump, and the jump is taken once the stall clears.
    s = idle(); s.ex_memread = 1'b1; s.ex_rd = 5'd5; s.rt = 5'd5; s.uses_rt = 1'b1;
    s.jump = 1'b1;
    step("prio_stall", s);
    s = idle(); s.jump = 1'b1;
    step("prio_jump", s);

    // Reset asserted between edges while the MD counter is at 2.
    s = idle(); s.md_start = 1'b1;
    step("rst_md_start", s);
    s = idle(); s.is_mfhilo = 1'b1;
    step("rst_md_wait", s);
    step("rst_md_wait", s);
    s.rst = 1'b1;
    step("rst_mid", s);
    step("rst_release", idle());

    // Stall counter saturation.
    s = idle(); s.ex_memread = 1'b1; s.ex_rd = 5'd3; s.rs = 5'd3;
    for (int i = 0; i < 20; i++) step("saturate", s);
    step("saturate_end", idle());

    // Randomized traffic with small register numbers so that matches are frequent.
    for (int i = 0; i < 300; i++) begin
      s.rst         = ($urandom_range(0, 59) == 0);
      s.rs          = 5'($urandom_range(0, 3));
      s.rt          = 5'($urandom_range(0, 3));
      s.ex_rd       = 5'($urandom_range(0, 3));
      s.mem_rd      = 5'($urandom_range(0, 3));
      s.uses_rt     = 1'($urandom_range(0, 1));
      s.is_branch   = ($urandom_range(0, 3) == 0);
      s.is_mfhilo   = ($urandom_range(0, 5) == 0);
      s.is_md       = ($urandom_range(0, 7) == 0);
      s.ex_memread  = ($urandom_range(0, 3) == 0);
      s.ex_regwrite = 1'($urandom_range(0, 1));
      s.mem_memread = ($urandom_range(0, 3) == 0);
      s.md_start    = ($urandom_range(0, 9) == 0);
      s.taken       = ($urandom_range(0, 4) == 0);
      s.jump        = ($urandom_range(0, 6) == 0);
      step("random", s);
    end

    // Let the monitor drain the queue, within a bound.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Stall/flush side of the 5-stage MIPS pipeline's hazard handling.
- The forwarding mux selects cover every RAW case they can resolve; this block covers the rest:
  - load-use stalls
  - branch-in-ID operand stalls
  - multiply/divide busy interlock
  - control flush on taken branch/jump
- Sits beside the ID stage. Drives PC and IF/ID write enables, ID/EX bubble insertion and IF/ID flush. Keeps the MD busy counter and performance counters.

Parameters:
- MD_LATENCY, 32, cycles the multiply/divide unit stays busy after md_start (1..63).
- CNT_W, 32, width of the stall and flush performance counters.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous reset, active high.
- IF_id_rs  input  5  rs field of the instruction in ID.
- IF_id_rt  input  5  rt field of the instruction in ID.
- IF_id_uses_rt  input  1  ID instruction reads rt as a source.
- IF_id_is_branch  input  1  ID instruction is beq/bne (compared in ID).
- IF_id_is_mfhilo  input  1  ID instruction is mfhi/mflo.
- IF_id_is_md  input  1  ID instruction is mult/div.
- ID_ex_memread  input  1  EX instruction is a load.
- ID_ex_regwrite  input  1  EX instruction writes a register.
- ID_ex_rd  input  5  EX destination register (after RegDst mux).
- EX_mem_memread  input  1  MEM instruction is a load.
- EX_mem_rd  input  5  MEM destination register.
- md_start  input  1  mult/div issued in EX this cycle.
- branch_taken  input  1  ID branch resolved taken.
- jump  input  1  ID instruction is j/jal/jr.
- pc_write  output  1  PC update enable.
- IF_id_write  output  1  IF/ID register write enable.
- ID_ex_bubble  output  1  zero control signals into ID/EX.
- IF_id_flush  output  1  replace IF/ID contents with nop.
- md_busy  output  1  MD unit still computing.
- stall_count  output  CNT_W  total stall cycles since reset.
- flush_count  output  CNT_W  total flushes since reset.

Behaviour:
- Reset (async, rst=1): md counter=0, md_busy=0, both perf counters=0, pc_write=0, IF_id_write=0, ID_ex_bubble=1, IF_id_flush=0. Values hold for as long as rst is high. On deassertion, normal evaluation starts the same cycle.
- Source match definitions:
  - A register r "matches" if r!=0 and (r==IF_id_rs, or IF_id_uses_rt and r==IF_id_rt).
  - For branches, rt is always a source regardless of IF_id_uses_rt.
- Stall conditions, combinational, evaluated every cycle:
  - load_use = ID_ex_memread && match(ID_ex_rd).
  - br_ex = IF_id_is_branch && ID_ex_regwrite && match(ID_ex_rd).
  - br_mem = IF_id_is_branch && EX_mem_memread && match(EX_mem_rd).
  - md_hz = md_busy && (IF_id_is_mfhilo || IF_id_is_md).
  - stall = load_use | br_ex | br_mem | md_hz.
- Stall behaviour: pc_write=0, IF_id_write=0, ID_ex_bubble=1, IF_id_flush=0. IF and ID hold.
- Resulting stall lengths: a branch after a load stalls 2 cycles (br_ex, then br_mem). An ALU producer before a branch stalls 1 cycle.
- No stall: pc_write=1, IF_id_write=1, ID_ex_bubble=0. IF_id_flush=branch_taken|jump.
- Stall has priority over flush. branch_taken/jump are ignored during a stall and re-evaluated once the stall clears.
- MD counter, 6-bit:
  - md_start loads MD_LATENCY; md_start while busy reloads.
  - Otherwise it decrements when nonzero.
  - md_busy = (counter!=0), registered. It asserts the cycle after md_start and stays high exactly MD_LATENCY cycles.
- stall_count increments on every cycle with stall=1 and rst=0. flush_count increments on every cycle with IF_id_flush=1. Both saturate at all-ones, no wrap.
- Outputs pc_write, IF_id_write, ID_ex_bubble and IF_id_flush are combinational from inputs and registered state: zero-cycle latency.

Decomposition:
- Shared package: register-zero constant (5'd0) and counter widths, for reuse with the forwarding logic.
- One natural sub-module: md_busy_counter (load/decrement/busy flag).

Test Plan:
- Load-use: ID_ex_memread=1, ID_ex_rd=8, IF_id_rs=8 -> one cycle with pc_write=0, IF_id_write=0, ID_ex_bubble=1; stall_count=1. Same stimulus with ID_ex_rd=0 -> no stall.
- Branch after load: lw $9 then beq $9,$10 -> 2 stall cycles (br_ex, then br_mem), then IF_id_flush=1 if branch_taken=1; stall_count=2, flush_count=1.
- MD interlock: MD_LATENCY=4, md_start pulse, mfhi in ID the next cycle -> stall for 4 cycles, release on the 5th; md_busy high exactly 4 cycles.
- Stall vs flush priority: load_use=1 with jump=1 -> IF_id_flush=0. The following cycle, with no hazard and jump=1 -> IF_id_flush=1, pc_write=1.
- Reset mid-stall: assert rst during an MD wait with counter=2 -> md_busy=0, counters=0, pc_write=0 and ID_ex_bubble=1 immediately (async). After release, with no hazard -> pc_write=1.
- Counter saturation: CNT_W=4, hold a stall for 20 cycles -> stall_count stops at 15.
